// File: rtl/port_uart_tx.sv
// port_uart_tx: byte-wide 8N1 UART transmitter for the output-port bus.
// tx_data and tx_start come from output ports. A 0->1 transition on
// tx_start launches one frame. status = {6'b0, done, busy} goes to an
// input port so the CPU can poll it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for a tx_start rising edge
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); a new edge here at terminal count chains
//       | straight into the next frame
module port_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic [7:0] status
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        start_q;
  logic        busy;
  logic        done;
  logic        start_edge;
  logic        baud_tc;
  logic        accept;

  assign start_edge = tx_start & ~start_q;
  assign baud_tc    = (baud_cnt == BAUD_LAST);
  // A frame may begin from idle, or on the very edge the stop bit ends.
  assign accept     = start_edge & ((state == IDLE) | ((state == STOP) & baud_tc));
  assign status     = {6'b0, done, busy};

  // Edge-detect history; reset to 1 so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) start_q <= 1'b1;
    else        start_q <= tx_start;
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= tx_data;
      done      <= 1'b0;
      busy      <= 1'b1;
      tx        <= 1'b0;
      baud_cnt  <= '0;
      state     <= START;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx (CLKS_PER_BIT = 4). Expected line/status values
// per cycle are queued when a frame is launched and compared on every
// falling clock edge; an empty queue means the line should be idle.
module tb_port_uart_tx;

  localparam int C = 4;

  typedef struct {
    logic       tx;
    logic [7:0] status;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start slot, bit 9 = stop slot
    bit         b2b;    // launch on the edge the previous stop bit ends
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b1;
  logic       tx;
  logic [7:0] status;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [7:0] idle_status = 8'h00;
  exp_t exp_q[$];
  vec_t vecs[5];

  port_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx(tx),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else begin
        e.tx     = 1'b1;
        e.status = idle_status;
      end
      check("tx", {7'b0, tx}, {7'b0, e.tx});
      check("status", status, e.status);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Raise tx_start (the caller ensures it was low), queue the expected frame,
  // drop tx_start after one cycle.
  task automatic send_frame(input logic [9:0] frame);
    exp_t e;
    tx_start = 1'b1;
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < C; k++) begin
        e.tx     = frame[s];
        e.status = 8'h01;
        exp_q.push_back(e);
      end
    end
    idle_status = 8'h02;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_empty: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h00, 10'h200, 1'b0};
    vecs[1] = '{8'hFF, 10'h3FE, 1'b1};
    vecs[2] = '{8'h3C, 10'h278, 1'b0};
    vecs[3] = '{8'h81, 10'h302, 1'b1};
    vecs[4] = '{8'h5A, 10'h2B4, 1'b1};

    // Reset with tx_start high; release must not launch a frame.
    #22;
    check("rst_tx", {7'b0, tx}, 8'h01);
    check("rst_status", status, 8'h00);
    step();
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (50) step();

    // Single frame 0xA5 with a re-trigger and data change mid-frame.
    tx_start = 1'b0;
    step();
    tx_data = 8'hA5;
    send_frame(10'h34A);
    repeat (10) step();
    tx_data = 8'hFF;
    tx_start = 1'b1;
    repeat (3) step();
    tx_start = 1'b0;
    step();
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    wait_empty();
    repeat (8) step();

    // Table of frames; b2b entries chain straight after the previous stop bit.
    for (int i = 0; i < 5; i++) begin
      tx_data = vecs[i].data;
      if (!vecs[i].b2b) repeat (3) step();
      send_frame(vecs[i].frame);
      repeat (5) step();
      tx_data = ~vecs[i].data;
      wait_empty();
    end
    repeat (4) step();

    // Reset in the middle of a frame.
    tx_data = 8'hC3;
    send_frame(10'h386);
    repeat (14) step();
    mon_en = 1'b0;
    tx_start = 1'b1;
    reset = 1'b0;
    #1;
    check("midrst_tx", {7'b0, tx}, 8'h01);
    check("midrst_status", status, 8'h00);
    exp_q.delete();
    idle_status = 8'h00;
    step();
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (10) step();
    tx_start = 1'b0;
    step();
    tx_data = 8'h96;
    send_frame(10'h32C);
    wait_empty();
    repeat (4) step();

    // tx_start held high for 100 cycles yields exactly one frame.
    tx_data = 8'h0F;
    send_frame(10'h21E);
    tx_start = 1'b1;
    repeat (99) step();
    tx_start = 1'b0;
    wait_empty();
    repeat (5) step();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
